// File: rtl/nfca_rx_miller_decoder_if.sv
// Received-frame beat bundle: tdata/tlast/tlastb plus end-of-frame status (err, crc_ok).
// No ready signal; the consumer must accept every beat on the cycle tvalid is high.
interface nfca_rx_miller_decoder_if;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tlast;
  logic [2:0] tlastb;
  logic       err;
  logic       crc_ok;

  modport master (output tvalid, tdata, tlast, tlastb, err, crc_ok);
  modport slave  (input  tvalid, tdata, tlast, tlastb, err, crc_ok);
endinterface

// File: rtl/nfca_rx_miller_decoder.sv
// ISO14443A Modified Miller decoder: pause detect, X/Y/Z slot classing, byte/parity assembly; beats lag one byte, last beat <=2 clk after EOF, no backpressure.
// Optional CRC_A residue check on the last beat under `NFCA_RX_CRC_CHECK_EN; otherwise rx.crc_ok is tied low.
module nfca_rx_miller_decoder #(
  parameter int BIT_CLKS   = 768,
  parameter int PAUSE_CLKS = 16,
  parameter int MAX_BYTES  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic carrier_in,
  nfca_rx_miller_decoder_if.master rx
);

  localparam int TW = $clog2(BIT_CLKS);
  localparam int PW = $clog2(PAUSE_CLKS + 1);
  localparam int BW = $clog2(MAX_BYTES + 1);

  localparam logic [TW-1:0] T_Q   = TW'(BIT_CLKS / 4);
  localparam logic [TW-1:0] T_H   = TW'(BIT_CLKS / 2);
  localparam logic [TW-1:0] T_3Q  = TW'(3 * BIT_CLKS / 4);
  localparam logic [TW-1:0] T_END = TW'(BIT_CLKS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RX    = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_LAST  = 2'd3;

  logic          c_s1, c_s2, c_s3;
  logic [PW-1:0] edge_cnt;
  logic          rise;
  logic          pause_evt;

  logic [1:0]    state;
  logic [TW-1:0] t;
  logic          x_seen, z_seen, sof_slot, prev_bit;
  logic          bit_pend, bit_pend_vld;
  logic [7:0]    shreg;
  logic [3:0]    n;
  logic [7:0]    pend_byte;
  logic          pend_vld;
  logic          err;
  logic [BW-1:0] byte_cnt;
  logic          is_eof;
  logic          crc_good;

  assign rise      = c_s2 & ~c_s3;
  assign pause_evt = !rise && (edge_cnt == PW'(PAUSE_CLKS - 1));
  assign is_eof    = !x_seen && !z_seen && !prev_bit;

`ifdef NFCA_RX_CRC_CHECK_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_a_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  assign crc_good = (crc == 16'h0000) && (byte_cnt >= BW'(3)) && (n == 4'd0);
`else
  assign crc_good = 1'b0;
`endif

  // Edge counter saturates so a held-low carrier yields a single pause pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_s1     <= 1'b0;
      c_s2     <= 1'b0;
      c_s3     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      c_s1 <= carrier_in;
      c_s2 <= c_s1;
      c_s3 <= c_s2;
      if (rise)
        edge_cnt <= '0;
      else if (edge_cnt != PW'(PAUSE_CLKS))
        edge_cnt <= edge_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      t            <= '0;
      x_seen       <= 1'b0;
      z_seen       <= 1'b0;
      sof_slot     <= 1'b0;
      prev_bit     <= 1'b0;
      bit_pend     <= 1'b0;
      bit_pend_vld <= 1'b0;
      shreg        <= '0;
      n            <= '0;
      pend_byte    <= '0;
      pend_vld     <= 1'b0;
      err          <= 1'b0;
      byte_cnt     <= '0;
`ifdef NFCA_RX_CRC_CHECK_EN
      crc          <= 16'h6363;
`endif
      rx.tvalid    <= 1'b0;
      rx.tdata     <= '0;
      rx.tlast     <= 1'b0;
      rx.tlastb    <= '0;
      rx.err       <= 1'b0;
      rx.crc_ok    <= 1'b0;
    end else begin
      rx.tvalid <= 1'b0;
      rx.tdata  <= '0;
      rx.tlast  <= 1'b0;
      rx.tlastb <= '0;
      rx.err    <= 1'b0;
      rx.crc_ok <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pause_evt) begin
            state        <= S_RX;
            t            <= '0;
            x_seen       <= 1'b0;
            z_seen       <= 1'b0;
            sof_slot     <= 1'b1;
            prev_bit     <= 1'b0;
            bit_pend_vld <= 1'b0;
            n            <= '0;
            pend_vld     <= 1'b0;
            err          <= 1'b0;
            byte_cnt     <= '0;
`ifdef NFCA_RX_CRC_CHECK_EN
            crc          <= 16'h6363;
`endif
          end
        end

        S_RX: begin
          // Each decoded bit is held one slot so the EOF logic-0 can be dropped.
          if (t == T_3Q) begin
            sof_slot <= 1'b0;
            if (!sof_slot) begin
              z_seen <= 1'b0;
              if (is_eof) begin
                state        <= S_FLUSH;
                bit_pend_vld <= 1'b0;
              end else begin
                bit_pend     <= x_seen;
                bit_pend_vld <= 1'b1;
                prev_bit     <= x_seen;
                if (bit_pend_vld) begin
                  if (n == 4'd8) begin
                    if (!(^{shreg, bit_pend}))
                      err <= 1'b1;
                    n <= '0;
                    if (byte_cnt == BW'(MAX_BYTES)) begin
                      err <= 1'b1;
                    end else begin
                      byte_cnt  <= byte_cnt + BW'(1);
                      pend_byte <= shreg;
                      pend_vld  <= 1'b1;
`ifdef NFCA_RX_CRC_CHECK_EN
                      crc       <= crc_a_byte(crc, shreg);
`endif
                      if (pend_vld) begin
                        rx.tvalid <= 1'b1;
                        rx.tdata  <= pend_byte;
                      end
                    end
                  end else begin
                    shreg <= {bit_pend, shreg[7:1]};
                    n     <= n + 4'd1;
                  end
                end
              end
            end
          end

          // A pause mid-slot is X; anything near a slot boundary starts a Z slot.
          if (pause_evt) begin
            if (t >= T_Q && t < T_3Q) begin
              x_seen <= 1'b1;
              t      <= T_H;
            end else begin
              z_seen <= 1'b1;
              x_seen <= 1'b0;
              t      <= '0;
            end
          end else if (t == T_END) begin
            t      <= '0;
            x_seen <= 1'b0;
          end else begin
            t <= t + TW'(1);
          end
        end

        S_FLUSH: begin
          if (pend_vld) begin
            rx.tvalid <= 1'b1;
            rx.tdata  <= pend_byte;
            pend_vld  <= 1'b0;
            if (n == 4'd0) begin
              rx.tlast  <= 1'b1;
              rx.tlastb <= 3'd7;
              rx.err    <= err;
              rx.crc_ok <= crc_good;
              err       <= 1'b0;
              state     <= S_IDLE;
            end else begin
              state <= S_LAST;
            end
          end else begin
            if (n != 4'd0) begin
              rx.tvalid <= 1'b1;
              rx.tdata  <= shreg >> (4'd8 - n);
              rx.tlast  <= 1'b1;
              rx.tlastb <= 3'(n - 4'd1);
              rx.err    <= err;
              rx.crc_ok <= crc_good;
            end
            err   <= 1'b0;
            n     <= '0;
            state <= S_IDLE;
          end
        end

        default: begin
          rx.tvalid <= 1'b1;
          rx.tdata  <= shreg >> (4'd8 - n);
          rx.tlast  <= 1'b1;
          rx.tlastb <= 3'(n - 4'd1);
          rx.err    <= err;
          rx.crc_ok <= crc_good;
          err       <= 1'b0;
          n         <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
